// File: rtl/sobel_grad_3x3_if.sv
// sobel_grad_3x3_if: column-in / gradient-out bundle between line buffer, sobel stage and NMS.
interface sobel_grad_3x3_if;
    logic       in_valid;
    logic       frame_start;
    logic [2:0] pix_top;
    logic [2:0] pix_mid;
    logic [2:0] pix_bot;
    logic       out_valid;
    logic [5:0] grad_mag;
    logic [1:0] grad_dir;
    logic       border;
    logic       frame_done;
    modport master (
        output in_valid, frame_start, pix_top, pix_mid, pix_bot,
        input  out_valid, grad_mag, grad_dir, border, frame_done
    );
    modport slave (
        input  in_valid, frame_start, pix_top, pix_mid, pix_bot,
        output out_valid, grad_mag, grad_dir, border, frame_done
    );
endinterface

// File: rtl/sobel_grad_3x3.sv
// sobel_grad_3x3: 3x3 Sobel window, 2-stage pipeline to |Gx|+|Gy| and border/frame tags.
// Define SOBEL_DIR_EN to build direction quantisation; otherwise grad_dir is tied to 0.
module sobel_grad_3x3 #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int CW     = 9,
    parameter int RW     = 8
) (
    input logic             clk,
    input logic             rst,
    sobel_grad_3x3_if.slave s
);
    logic [8:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic [CW-1:0] col_q, col_d, tcol_q, tcol_d, ecol;
    logic [RW-1:0] row_q, row_d, trow_q, trow_d, erow;
    logic wrap_c, wrap_r;
    logic v0_q, v0_d, v1_q, v1_d, ov_q, ov_d;
    logic last0_q, last0_d, last1_q, last1_d, fd_q, fd_d;
    logic bd1_q, bd1_d, bd2_q, bd2_d;
    logic signed [5:0] gx_q, gx_d, gy_q, gy_d;
    logic [5:0] ax, ay, mag_q, mag_d;
    logic [1:0] dir_q, dir_d;

    // 1-2-1 weighted sum of three pixels
    function automatic logic [5:0] wsum(logic [2:0] a, logic [2:0] b, logic [2:0] c);
        return 6'(a) + 6'({b, 1'b0}) + 6'(c);
    endfunction

    // S0: shift window, tag position (frame_start overrides the counters)
    always_comb begin
        ecol    = s.frame_start ? '0 : col_q;
        erow    = s.frame_start ? '0 : row_q;
        wrap_c  = ecol == CW'(WIDTH - 1);
        wrap_r  = erow == RW'(HEIGHT - 1);
        c0_d    = s.in_valid ? c1_q : c0_q;
        c1_d    = s.in_valid ? c2_q : c1_q;
        c2_d    = s.in_valid ? {s.pix_top, s.pix_mid, s.pix_bot} : c2_q;
        col_d   = !s.in_valid ? col_q : wrap_c ? '0 : ecol + CW'(1);
        row_d   = !s.in_valid ? row_q : !wrap_c ? erow : wrap_r ? '0 : erow + RW'(1);
        tcol_d  = s.in_valid ? ecol : tcol_q;
        trow_d  = s.in_valid ? erow : trow_q;
        last0_d = s.in_valid ? (wrap_c & wrap_r) : last0_q;
        v0_d    = s.in_valid;
    end

    // S1: Gx is right column minus left column, Gy is bottom row minus top row
    always_comb begin
        gx_d    = $signed(wsum(c2_q[8:6], c2_q[5:3], c2_q[2:0]) - wsum(c0_q[8:6], c0_q[5:3], c0_q[2:0]));
        gy_d    = $signed(wsum(c0_q[2:0], c1_q[2:0], c2_q[2:0]) - wsum(c0_q[8:6], c1_q[8:6], c2_q[8:6]));
        bd1_d   = (tcol_q < CW'(2)) || (trow_q < RW'(2));
        last1_d = v0_q & last0_q;
        v1_d    = v0_q;
    end

    // S2: magnitude and quantised direction; border results are zeroed
    always_comb begin
        ax    = gx_q[5] ? 6'(-gx_q) : 6'(gx_q);
        ay    = gy_q[5] ? 6'(-gy_q) : 6'(gy_q);
        mag_d = bd1_q ? '0 : ax + ay;
`ifdef SOBEL_DIR_EN
        dir_d = bd1_q                           ? 2'd0 :
                ({ay, 1'b0} <= {1'b0, ax})      ? 2'd0 :
                ({ax, 1'b0} <= {1'b0, ay})      ? 2'd2 :
                (gx_q[5] == gy_q[5])            ? 2'd1 : 2'd3;
`else
        dir_d = 2'd0;
`endif
        bd2_d = v1_q & bd1_q;
        fd_d  = last1_q;
        ov_d  = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            tcol_q  <= '0;
            trow_q  <= '0;
            last0_q <= 1'b0;
            v0_q    <= 1'b0;
            gx_q    <= '0;
            gy_q    <= '0;
            bd1_q   <= 1'b0;
            last1_q <= 1'b0;
            v1_q    <= 1'b0;
            mag_q   <= '0;
            dir_q   <= '0;
            bd2_q   <= 1'b0;
            fd_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tcol_q  <= tcol_d;
            trow_q  <= trow_d;
            last0_q <= last0_d;
            v0_q    <= v0_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            bd1_q   <= bd1_d;
            last1_q <= last1_d;
            v1_q    <= v1_d;
            mag_q   <= mag_d;
            dir_q   <= dir_d;
            bd2_q   <= bd2_d;
            fd_q    <= fd_d;
            ov_q    <= ov_d;
        end
    end

    assign s.out_valid  = ov_q;
    assign s.grad_mag   = mag_q;
    assign s.grad_dir   = dir_q;
    assign s.border     = bd2_q;
    assign s.frame_done = fd_q;
endmodule

// File: tb/tb_sobel_grad_3x3.sv
// tb_sobel_grad_3x3: directed vectors on an 8x4 frame, plus frame-wrap and async-reset sequences.
module tb_sobel_grad_3x3;
    localparam int W = 8;
    localparam int H = 4;
`ifdef SOBEL_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif
    localparam logic [8:0] FILL = 9'h16D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;

    sobel_grad_3x3_if bus ();
    sobel_grad_3x3 #(.WIDTH(W), .HEIGHT(H), .CW(3), .RW(2)) dut (.clk(clk), .rst(rst), .s(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] mag;
        logic [1:0] dir;
        logic       border;
        logic       fd;
    } res_t;

    typedef struct {
        logic [8:0] c0;
        logic [8:0] c1;
        logic [8:0] c2;
        int         mag;
        int         dir;
    } vec_t;

    res_t q[$];
    vec_t v[9];

    always @(negedge clk) if (bus.out_valid) q.push_back({bus.grad_mag, bus.grad_dir, bus.border, bus.frame_done});

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic put(logic fs, logic [8:0] c);
        bus.in_valid    = 1'b1;
        bus.frame_start = fs;
        {bus.pix_top, bus.pix_mid, bus.pix_bot} = c;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Window lands at tag (2,2): 16 fill columns then c0, c1, c2
    task automatic run_vec(int i);
        put(1'b1, FILL);
        repeat (15) put(1'b0, FILL);
        put(1'b0, v[i].c0);
        put(1'b0, v[i].c1);
        put(1'b0, v[i].c2);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_prev_border", i), int'(bus.border), 1);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), 1);
        chk($sformatf("vec%0d_mag", i), int'(bus.grad_mag), v[i].mag);
        chk($sformatf("vec%0d_dir", i), int'(bus.grad_dir), DIR_EN ? v[i].dir : 0);
        chk($sformatf("vec%0d_border", i), int'(bus.border), 0);
        @(negedge clk);
    endtask

    initial begin
        int fd_cnt;
        res_t e;
        v[0] = '{9'h000, 9'h1FF, 9'h1FF, 28, 0};
        v[1] = '{9'h03F, 9'h03F, 9'h03F, 28, 2};
        v[2] = '{9'h000, 9'h000, 9'h007, 14, 1};
        v[3] = '{9'h007, 9'h000, 9'h000, 14, 3};
        v[4] = '{9'h1C0, 9'h000, 9'h000, 14, 1};
        v[5] = '{9'h000, 9'h001, 9'h010, 6, 0};
        v[6] = '{9'h000, 9'h002, 9'h008, 6, 2};
        v[7] = '{9'h000, 9'h000, 9'h1C0, 14, 3};
        v[8] = '{9'h000, 9'h000, 9'h000, 0, 0};
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_top     = '0;
        bus.pix_mid     = '0;
        bus.pix_bot     = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_mag", int'(bus.grad_mag), 0);
        chk("rst_dir", int'(bus.grad_dir), 0);
        chk("rst_border", int'(bus.border), 0);
        chk("rst_fd", int'(bus.frame_done), 0);
        rst = 1'b0;
        idle(2);

        // Uniform frame plus one column into the next frame
        q.delete();
        put(1'b1, FILL);
        repeat (32) put(1'b0, FILL);
        idle(4);
        chk("frame_count", q.size(), 33);
        for (int i = 0; i < 33 && i < q.size(); i++) begin
            e.mag    = '0;
            e.dir    = '0;
            e.border = ((i % W) < 2) || (((i / W) % H) < 2);
            e.fd     = (i == 31);
            chk($sformatf("frame[%0d]", i), int'(q[i]), int'(e));
        end

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
            idle(2);
        end

        // frame_start arrives on the last column of a frame
        q.delete();
        put(1'b1, FILL);
        repeat (30) put(1'b0, FILL);
        run_vec(0);
        idle(3);
        chk("wrap_fs_count", q.size(), 50);
        fd_cnt = 0;
        foreach (q[i]) fd_cnt += int'(q[i].fd);
        chk("wrap_fs_no_done", fd_cnt, 0);

        // Async reset with two results in flight
        q.delete();
        put(1'b1, 9'h1FF);
        repeat (4) put(1'b0, 9'h1FF);
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        chk("pre_rst_border", int'(bus.border), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", int'(bus.out_valid), 0);
        chk("async_border", int'(bus.border), 0);
        chk("async_mag", int'(bus.grad_mag), 0);
        chk("async_fd", int'(bus.frame_done), 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("no_stale", q.size(), 0);
        put(1'b1, 9'h1FF);
        put(1'b0, 9'h000);
        put(1'b0, 9'h1FF);
        idle(4);
        chk("post_rst_count", q.size(), 3);
        foreach (q[i]) chk($sformatf("post_rst_border[%0d]", i), int'(q[i].border), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_grad_3x3.md
Name: sobel_grad_3x3

Overview:
Gradient stage placed directly downstream of the 3-row line buffer. Each cycle it accepts one vertically aligned column of 3-bit pixels (oldest row, middle row, newest row) and shifts it into a 3x3 window. It computes Sobel Gx/Gy over that window through a fixed 2-stage pipeline and emits the gradient magnitude |Gx|+|Gy| and a quantised direction for the non-maximum-suppression stage. Frame column/row counters flag border outputs, which carry magnitude 0.

Parameters:
WIDTH, 320, pixels per line; must match the line buffer depth
HEIGHT, 240, lines per frame
CW, 9, column counter width; must satisfy 2^CW >= WIDTH
RW, 8, row counter width; must satisfy 2^RW >= HEIGHT

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  column present this cycle; driven by ld delayed one cycle to align with the buffer's registered outputs
frame_start  in  1  qualified by in_valid; this column is (row 0, col 0)
pix_top  in  3  pixel at row y-1 (line buffer out_data1)
pix_mid  in  3  pixel at row y (out_data2)
pix_bot  in  3  pixel at row y+1, the current input (out_data3)
out_valid  out  1  result valid
grad_mag  out  6  |Gx|+|Gy|, unsigned, range 0..56
grad_dir  out  2  0=0deg, 1=45deg, 2=90deg, 3=135deg
border  out  1  window incomplete; grad_mag forced to 0
frame_done  out  1  one-cycle pulse with the result of the last pixel of a frame

Behaviour:
- Reset (async, rst=1): window, col/row counters, pipeline registers, out_valid, grad_mag, grad_dir, border and frame_done all clear to 0. Reset mid-frame discards in-flight results. The next frame restarts at (0,0).
- S0 (edge where in_valid=1):
  - Columns shift c0<=c1, c1<=c2, c2<={top,mid,bot}. c2 is the rightmost column.
  - The position tag (col,row) used is the pre-increment counter value. If frame_start=1, the tag is forced to (0,0).
  - Counter update: col++. At col==WIDTH-1, col<=0 and row++. At col==WIDTH-1 and row==HEIGHT-1, both counters wrap to 0 and the last flag is set.
  - If in_valid=0, the window and counters hold.
- Window pixel naming: p[r][c], r=0 top, c=0 left.
- S1 (next edge): register signed 6-bit gradients.
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Register the border and last tags alongside.
  - border = (col_tag<2) or (row_tag<2).
- S2 (next edge): compute the output.
  - grad_mag = border ? 0 : |Gx|+|Gy|. Max 56, so no saturation is needed.
  - Direction, with ax=|Gx| and ay=|Gy|:
    - 2*ay <= ax gives 0.
    - Otherwise 2*ax <= ay gives 2.
    - Otherwise sign(Gx)==sign(Gy) gives 1, else 3.
    - Ties resolve in that order.
  - grad_dir = 0 when border=1.
- Valid pipeline:
  - out_valid is high exactly 2 edges after the S0 edge. It is a pure delay line with no stall.
  - Every accepted column produces exactly one output, including border outputs.
  - Back-to-back in_valid gives back-to-back out_valid.
- frame_done equals the S2-registered last tag, so it rises together with out_valid of the final pixel.
- Simultaneous events:
  - frame_start on a wrap column: frame_start wins, tag (0,0), and the counters advance to (1,0).
  - A new column entering in the same cycle as an output is normal pipelined operation.

Optional Feature:
Macro SOBEL_DIR_EN.
- Defined: direction quantisation logic is present and grad_dir behaves as above.
- Undefined: the direction compare logic is not built and grad_dir is tied to 2'b00. All other outputs and the latency are unchanged.

Test Plan:
1. Uniform frame, all pixels 5, WIDTH=8, HEIGHT=4 -> 32 out_valid pulses. Interior grad_mag=0. Border=1 on the first two columns of every row and on all of rows 0-1.
2. Interior window with c0=0 and c1=c2=7 in all rows -> Gx=28, Gy=0, grad_mag=28, grad_dir=0, 2 edges after the in_valid edge.
3. Interior window with top row 0 and mid/bot rows 7 -> grad_mag=28, grad_dir=2.
4. Only p22=7 -> grad_mag=14, grad_dir=1. Only p20=7 -> grad_mag=14, grad_dir=3. With SOBEL_DIR_EN undefined, grad_dir=0 in both cases.
5. WIDTH=8, HEIGHT=4, 32 consecutive in_valid columns -> frame_done pulses once, on the 32nd out_valid. The counters restart and the next output is border=1 at (0,0).
6. Assert rst asynchronously mid-row with 2 results in flight -> all outputs drop to 0 immediately and no stale out_valid appears. After release, frame_start plus 3 columns -> 3 outputs with border=1.
